// File: rtl/trig_controller_if.sv
// Request/response handshake bundle between a requester and trig_controller.
interface trig_controller_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] req_angle;
   logic                  req_func;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_result;
   logic [1:0]            rsp_quadrant;
   logic                  rsp_error;

   modport master (
      output req_valid, req_angle, req_func, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_quadrant, rsp_error
   );

   modport slave (
      input  req_valid, req_angle, req_func, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_quadrant, rsp_error
   );
endinterface

// File: rtl/trig_controller.sv
// Sequences one sine/cosine request through an external range reducer and
// evaluator, then applies the quadrant sign and holds the response.
module trig_controller #(
   parameter int DATA_WIDTH = 64,
   parameter int REDUCE_LAT = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   trig_controller_if.slave      bus,
   output logic                  en_divider,
   output logic [DATA_WIDTH-1:0] red_data_in,
   input  logic [1:0]            red_quadrant,
   input  logic [DATA_WIDTH-1:0] red_data,
   output logic                  eval_start,
   output logic [DATA_WIDTH-1:0] eval_angle,
   output logic                  eval_func,
   input  logic                  eval_done,
   input  logic [DATA_WIDTH-1:0] eval_result
);

   localparam logic [3:0] RED_LOAD  = 4'(REDUCE_LAT - 1);
   localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, REDUCE, EVAL_REQ, EVAL_WAIT, RESP} state_t;

   state_t                state, state_nxt;
   logic [3:0]            red_cnt, red_cnt_nxt;
   logic [9:0]            wait_cnt, wait_cnt_nxt;
   logic [DATA_WIDTH-1:0] angle_q, angle_nxt;
   logic [DATA_WIDTH-1:0] data_q, data_nxt;
   logic [DATA_WIDTH-1:0] result_q, result_nxt;
   logic                  func_q, func_nxt;
   logic [1:0]            quad_q, quad_nxt;
   logic                  error_q, error_nxt;
   logic                  neg;
   logic                  ready_q, en_q, start_q, valid_q;

   // Result sign: sine negative in quadrants 2,3; cosine in quadrants 1,2.
   assign neg = func_q ? (quad_q == 2'b01 || quad_q == 2'b10) : quad_q[1];

   always_comb begin
      state_nxt    = state;
      red_cnt_nxt  = red_cnt;
      wait_cnt_nxt = wait_cnt;
      angle_nxt    = angle_q;
      data_nxt     = data_q;
      result_nxt   = result_q;
      func_nxt     = func_q;
      quad_nxt     = quad_q;
      error_nxt    = error_q;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               angle_nxt   = bus.req_angle;
               func_nxt    = bus.req_func;
               red_cnt_nxt = RED_LOAD;
               state_nxt   = REDUCE;
            end
         end
         REDUCE: begin
            if (red_cnt == 4'd0) begin
               quad_nxt  = red_quadrant;
               data_nxt  = red_data;
               state_nxt = EVAL_REQ;
            end else begin
               red_cnt_nxt = red_cnt - 4'd1;
            end
         end
         EVAL_REQ: begin
            wait_cnt_nxt = '0;
            state_nxt    = EVAL_WAIT;
         end
         EVAL_WAIT: begin
            if (eval_done) begin
               result_nxt = {eval_result[DATA_WIDTH-1] ^ neg, eval_result[DATA_WIDTH-2:0]};
               error_nxt  = 1'b0;
               state_nxt  = RESP;
            end else if (wait_cnt == WAIT_LAST) begin
               result_nxt = '0;
               error_nxt  = 1'b1;
               state_nxt  = RESP;
            end else begin
               wait_cnt_nxt = wait_cnt + 10'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control outputs are decoded from the next state so they are flops
   // aligned with the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         red_cnt  <= '0;
         wait_cnt <= '0;
         angle_q  <= '0;
         data_q   <= '0;
         result_q <= '0;
         func_q   <= 1'b0;
         quad_q   <= '0;
         error_q  <= 1'b0;
         ready_q  <= 1'b1;
         en_q     <= 1'b0;
         start_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         red_cnt  <= red_cnt_nxt;
         wait_cnt <= wait_cnt_nxt;
         angle_q  <= angle_nxt;
         data_q   <= data_nxt;
         result_q <= result_nxt;
         func_q   <= func_nxt;
         quad_q   <= quad_nxt;
         error_q  <= error_nxt;
         ready_q  <= (state_nxt == IDLE);
         en_q     <= (state_nxt == REDUCE);
         start_q  <= (state_nxt == EVAL_REQ);
         valid_q  <= (state_nxt == RESP);
      end
   end

   assign bus.req_ready    = ready_q;
   assign bus.rsp_valid    = valid_q;
   assign bus.rsp_result   = result_q;
   assign bus.rsp_quadrant = quad_q;
   assign bus.rsp_error    = error_q;
   assign en_divider       = en_q;
   assign red_data_in      = angle_q;
   assign eval_start       = start_q;
   assign eval_angle       = data_q;
   assign eval_func        = func_q;

endmodule

// File: tb/tb_trig_controller.sv
// Scoreboard bench for trig_controller: models reducer/evaluator responses
// and checks latency, sign folding, timeout, backpressure and reset abort.
module tb_trig_controller;

   localparam int DW   = 64;
   localparam int RLAT = 2;
   localparam int TO   = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          en_divider;
   logic [DW-1:0] red_data_in;
   logic [1:0]    red_quadrant;
   logic [DW-1:0] red_data;
   logic          eval_start;
   logic [DW-1:0] eval_angle;
   logic          eval_func;
   logic          eval_done;
   logic [DW-1:0] eval_result;

   trig_controller_if #(.DATA_WIDTH(DW)) bus ();

   trig_controller #(.DATA_WIDTH(DW), .REDUCE_LAT(RLAT), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .en_divider   (en_divider),
      .red_data_in  (red_data_in),
      .red_quadrant (red_quadrant),
      .red_data     (red_data),
      .eval_start   (eval_start),
      .eval_angle   (eval_angle),
      .eval_func    (eval_func),
      .eval_done    (eval_done),
      .eval_result  (eval_result)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] result;
      logic [1:0]    quad;
      logic          error;
   } exp_t;

   exp_t sb[$];
   int   n_asserts = 0;
   int   n_fail    = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic model_neg(input logic func, input logic [1:0] quad);
      case ({func, quad})
         3'b0_10, 3'b0_11, 3'b1_01, 3'b1_10: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   task automatic sb_compare();
      exp_t e;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("rsp_result",   bus.rsp_result,   e.result);
         check("rsp_quadrant", bus.rsp_quadrant, e.quad);
         check("rsp_error",    bus.rsp_error,    e.error);
      end
   endtask

   // Entered and left on a falling edge with the controller idle.
   task automatic run_op(input logic [63:0] angle, input logic func, input logic [1:0] quad,
                         input logic [63:0] data, input logic [63:0] evres, input bit timeout,
                         input int ready_delay, input bit hold_next,
                         input logic [63:0] nangle, input logic nfunc);
      int   k, en_cnt, k_start, exp_lat;
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_angle = angle;
      bus.req_func  = func;
      red_quadrant  = quad;
      red_data      = data;
      check("req_ready_idle", bus.req_ready, 64'd1);
      e.result = timeout ? '0 : {evres[63] ^ model_neg(func, quad), evres[62:0]};
      e.quad   = quad;
      e.error  = timeout;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      k = 1;
      bus.req_valid = hold_next;
      if (hold_next) begin
         bus.req_angle = nangle;
         bus.req_func  = nfunc;
      end
      check("req_ready_busy", bus.req_ready, 64'd0);
      en_cnt  = 0;
      k_start = 0;
      while (k_start == 0 && k < 40) begin
         if (en_divider) begin
            en_cnt++;
            check("red_data_in", red_data_in, angle);
         end
         if (eval_start) begin
            k_start = k;
            check("eval_angle", eval_angle, data);
            check("eval_func",  eval_func,  func);
         end else begin
            @(negedge clk);
            k++;
         end
      end
      check("eval_start_cycle", k_start, 64'd3);
      check("en_divider_cycles", en_cnt, RLAT);
      @(negedge clk);
      k++;
      check("eval_start_pulse", eval_start, 64'd0);
      if (!timeout) begin
         eval_done   = 1'b1;
         eval_result = evres;
         @(negedge clk);
         k++;
         eval_done   = 1'b0;
         eval_result = '0;
      end
      while (!bus.rsp_valid && k < k_start + 40) begin
         @(negedge clk);
         k++;
      end
      exp_lat = timeout ? k_start + 1 + TO : 5;
      check("rsp_latency", k, exp_lat);
      for (int unsigned i = 0; i < ready_delay; i++) begin
         check("hold_valid",  bus.rsp_valid,  64'd1);
         check("hold_result", bus.rsp_result, e.result);
         check("hold_error",  bus.rsp_error,  e.error);
         check("hold_ready",  bus.req_ready,  64'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      sb_compare();
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rsp_valid_drop", bus.rsp_valid, 64'd0);
      check("req_ready_back", bus.req_ready, 64'd1);
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_angle = '0;
      bus.req_func  = 1'b0;
      bus.rsp_ready = 1'b0;
      red_quadrant  = '0;
      red_data      = '0;
      eval_done     = 1'b0;
      eval_result   = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready",  bus.req_ready, 64'd1);
      check("rst_rsp_valid",  bus.rsp_valid, 64'd0);
      check("rst_en_divider", en_divider,    64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(64'd30,  1'b0, 2'b00, 64'd30, 64'h3FE0000000000000, 1'b0, 0, 1'b0, '0, 1'b0);
      run_op(64'd210, 1'b0, 2'b10, 64'd30, 64'h3FE0000000000000, 1'b0, 0, 1'b0, '0, 1'b0);
      run_op(64'd120, 1'b1, 2'b01, 64'd60, 64'h3FE0000000000000, 1'b0, 4, 1'b0, '0, 1'b0);
      run_op(64'd330, 1'b1, 2'b11, 64'd30, 64'h3FEBB67AE8584CAA, 1'b0, 1, 1'b1, 64'd300, 1'b0);
      run_op(64'd300, 1'b0, 2'b11, 64'd60, 64'h3FEBB67AE8584CAA, 1'b0, 0, 1'b0, '0, 1'b0);
      run_op(64'd200, 1'b0, 2'b10, 64'd20, 64'h3FD0000000000000, 1'b1, 2, 1'b0, '0, 1'b0);

      // Abort a request in EVAL_WAIT, then send a late eval_done.
      bus.req_valid = 1'b1;
      bus.req_angle = 64'd100;
      bus.req_func  = 1'b1;
      red_quadrant  = 2'b01;
      red_data      = 64'd80;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int unsigned i = 0; i < 20 && !eval_start; i++) @(negedge clk);
      check("abort_eval_start", eval_start, 64'd1);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      reset       = 1'b0;
      eval_done   = 1'b1;
      eval_result = 64'h3FE0000000000000;
      check("abort_req_ready",    bus.req_ready,    64'd1);
      check("abort_rsp_valid",    bus.rsp_valid,    64'd0);
      check("abort_rsp_result",   bus.rsp_result,   64'd0);
      check("abort_rsp_quadrant", bus.rsp_quadrant, 64'd0);
      check("abort_rsp_error",    bus.rsp_error,    64'd0);
      check("abort_en_divider",   en_divider,       64'd0);
      check("abort_eval_start0",  eval_start,       64'd0);
      check("abort_red_data_in",  red_data_in,      64'd0);
      check("abort_eval_angle",   eval_angle,       64'd0);
      @(negedge clk);
      eval_done   = 1'b0;
      eval_result = '0;
      begin
         int seen = 0;
         for (int unsigned i = 0; i < 12; i++) begin
            if (bus.rsp_valid) seen++;
            @(negedge clk);
         end
         check("abort_no_response", seen, 64'd0);
      end

      run_op(64'd225, 1'b1, 2'b10, 64'd45, 64'h3FE6A09E667F3BCD, 1'b0, 0, 1'b0, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/trig_controller.md
TRIG_CONTROLLER -- requirements
Module: trig_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 64, angle and result word width.
REQ-002 Parameter REDUCE_LAT, default 2, number of cycles the range reducer is held enabled (range 1..15).
REQ-003 Parameter TIMEOUT, default 255, maximum evaluator wait cycles (range 1..1023).
REQ-004 clk  in  1  sole clock, all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller can accept request.
REQ-008 req_angle  in  DATA_WIDTH  input angle, unsigned integer degrees.
REQ-009 req_func  in  1  0 = sine, 1 = cosine.
REQ-010 en_divider  out  1  range-reducer enable.
REQ-011 red_data_in  out  DATA_WIDTH  angle driven to reducer.
REQ-012 red_quadrant  in  2  reducer quadrant.
REQ-013 red_data  in  DATA_WIDTH  reducer folded angle.
REQ-014 eval_start  out  1  one-cycle evaluator launch pulse.
REQ-015 eval_angle  out  DATA_WIDTH  folded angle to evaluator.
REQ-016 eval_func  out  1  function select to evaluator.
REQ-017 eval_done  in  1  evaluator result valid (single-cycle pulse).
REQ-018 eval_result  in  DATA_WIDTH  IEEE-754 magnitude result.
REQ-019 rsp_valid  out  1  response present.
REQ-020 rsp_ready  in  1  consumer accepts response.
REQ-021 rsp_result  out  DATA_WIDTH  signed IEEE-754 result.
REQ-022 rsp_quadrant  out  2  quadrant used for sign.
REQ-023 rsp_error  out  1  evaluator timeout flag.

Function
REQ-024 FSM states IDLE, REDUCE, EVAL_REQ, EVAL_WAIT, RESP; exactly one active; all outputs registered.
REQ-025 req_ready = 1 only in IDLE; accept = req_valid & req_ready; on accept latch req_angle, req_func, go REDUCE next cycle.
REQ-026 REDUCE: en_divider = 1, red_data_in = latched angle, for exactly REDUCE_LAT cycles (down-counter); en_divider = 0 in all other states.
REQ-027 On last REDUCE cycle, latch red_quadrant and red_data on that edge, go EVAL_REQ.
REQ-028 EVAL_REQ: eval_start = 1 for exactly one cycle, eval_angle = latched red_data, eval_func = latched func; go EVAL_WAIT; wait counter cleared.
REQ-029 EVAL_WAIT: eval_done sampled only here; eval_done outside EVAL_WAIT ignored.
REQ-030 On eval_done: rsp_result = eval_result with bit DATA_WIDTH-1 XORed with neg, rsp_error = 0, go RESP.
REQ-031 neg: sine -> 1 for quadrant 2'b10, 2'b11; cosine -> 1 for quadrant 2'b01, 2'b10; else 0.
REQ-032 If TIMEOUT cycles elapse in EVAL_WAIT without eval_done: rsp_result = 0, rsp_error = 1, go RESP.
REQ-033 RESP: rsp_valid = 1; rsp_result, rsp_quadrant, rsp_error stable until rsp_valid & rsp_ready, then IDLE next cycle.
REQ-034 Latency (REDUCE_LAT = 2, eval_done first EVAL_WAIT cycle): accept edge T, REDUCE T+1..T+2, eval_start T+3, eval_done T+4, rsp_valid T+5.
REQ-035 New request accepted earliest the cycle after the rsp handshake; no overlap, no queuing.
REQ-036 req_valid while busy has no effect; requester holds it.

Reset
REQ-037 reset at any edge, including mid-operation: state IDLE, req_ready = 1, en_divider = 0, eval_start = 0, rsp_valid = 0, rsp_result = 0, rsp_quadrant = 0, rsp_error = 0, counters 0, latched operands 0.
REQ-038 An eval_done arriving after reset is ignored; no response is produced for an aborted request.

Verification
REQ-039 angle 30, sine, reducer quadrant 00/data 30, eval_result 0x3FE0000000000000 one cycle after eval_start -> rsp_valid at T+5, rsp_result 0x3FE0000000000000, rsp_error 0.
REQ-040 angle 210, sine, quadrant 10/data 30, eval_result 0x3FE0000000000000 -> rsp_result 0xBFE0000000000000, rsp_quadrant 10.
REQ-041 angle 120, cosine, quadrant 01/data 60, eval_result 0x3FE0000000000000 -> rsp_result 0xBFE0000000000000; rsp_ready low 4 cycles -> outputs stable, req_ready 0 throughout.
REQ-042 TIMEOUT = 8, eval_done never asserted -> rsp_valid exactly 8 cycles after entering EVAL_WAIT, rsp_error 1, rsp_result 0.
REQ-043 reset pulsed during EVAL_WAIT, eval_done pulsed next cycle -> no rsp_valid, req_ready 1 the cycle after reset.
REQ-044 second req_valid held during busy period -> accepted the cycle after first rsp handshake, en_divider high exactly REDUCE_LAT cycles per request.
